// File: rtl/pll_lock_reset_seq_if.sv
// rtl/pll_lock_reset_seq_if.sv - PLL lock/reset and downstream reset signal bundle
interface pll_lock_reset_seq_if #(
  parameter int FAIL_W = 4
);
  logic              pll_lock;
  logic              pll_reset;
  logic              sys_rst_n;
  logic              locked;
  logic [FAIL_W-1:0] fail_count;
  logic [1:0]        state_dbg;

  modport master (
    input  pll_lock,
    output pll_reset, sys_rst_n, locked, fail_count, state_dbg
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_rst_n, locked, fail_count, state_dbg
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL reset pulse, lock qualification and downstream reset release
module pll_lock_reset_seq #(
  parameter int RST_CYCLES    = 100,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2,
  parameter int FAIL_W        = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  pll_lock_reset_seq_if.master   bus
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   fail_inc;
  logic [FAIL_W-1:0]      fail_q;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= RESET_PLL;
      cnt    <= '0;
      sync_q <= '0;
      fail_q <= '0;
    end else begin
      state  <= state_next;
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
      // RUN holds the counter so it can never wrap while locked indefinitely
      if (state_next != state) begin
        cnt <= '0;
      end else if (state != RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (fail_inc && (fail_q != '1)) begin
        fail_q <= fail_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    fail_inc   = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = RESET_PLL;
          fail_inc   = 1'b1;
        end
      end
      STABLE: begin
        // a dropout here is treated as a glitch, not a failure
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          fail_inc   = 1'b1;
        end
      end
      default: state_next = RESET_PLL;
    endcase
  end

  assign bus.pll_reset  = (state == RESET_PLL);
  assign bus.sys_rst_n  = (state == RUN);
  assign bus.locked     = (state == RUN);
  assign bus.fail_count = fail_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - scoreboard bench for pll_lock_reset_seq against a phase/time model
module tb_pll_lock_reset_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int FAIL_W        = 2;
  localparam int FAIL_MAX      = (1 << FAIL_W) - 1;

  logic clk = 1'b0;
  logic resetn;

  pll_lock_reset_seq_if #(.FAIL_W(FAIL_W)) bus ();

  pll_lock_reset_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES),
    .FAIL_W       (FAIL_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic              pll_reset;
    logic              sys_rst_n;
    logic              locked;
    logic [FAIL_W-1:0] fail_count;
    logic [1:0]        state_dbg;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: phase number, cycles spent in the phase, and a delay line for lock
  int m_phase;
  int m_t;
  int m_fails;
  bit m_sync[$];
  bit m_hist[$];

  function automatic void model_step(input bit rn, input bit lk);
    bit ls;
    int nxt;
    if (!rn) begin
      m_phase = 0;
      m_t     = 0;
      m_fails = 0;
      m_sync.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(1'b0);
      m_hist.delete();
      return;
    end
    ls = m_sync.pop_front();
    m_sync.push_back(lk);
    m_hist.push_back(ls);
    if (m_hist.size() > STABLE_CYCLES) void'(m_hist.pop_front());
    nxt = m_phase;
    case (m_phase)
      0: if (m_t + 1 == RST_CYCLES) nxt = 1;
      1: begin
        if (ls) nxt = 2;
        else if (m_t + 1 == LOCK_TIMEOUT) begin
          nxt = 0;
          if (m_fails < FAIL_MAX) m_fails++;
        end
      end
      2: begin
        if (!ls) nxt = 1;
        else if (m_t + 1 == STABLE_CYCLES) nxt = 3;
      end
      default: begin
        if (!ls) begin
          nxt = 1;
          if (m_fails < FAIL_MAX) m_fails++;
        end
      end
    endcase
    m_t     = (nxt == m_phase) ? m_t + 1 : 0;
    m_phase = nxt;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pll_reset  = (m_phase == 0);
    o.sys_rst_n  = (m_phase == 3);
    o.locked     = (m_phase == 3);
    o.fail_count = FAIL_W'(m_fails);
    o.state_dbg  = 2'(m_phase);
    return o;
  endfunction

  function automatic bit hist_ok();
    if (m_hist.size() < STABLE_CYCLES) return 1'b0;
    foreach (m_hist[i]) if (!m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input bit rn, input bit lk);
    @(negedge clk);
    resetn       = rn;
    bus.pll_lock = lk;
    model_step(rn, lk);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #2;
    check("never_both_high", 32'(bus.pll_reset & bus.sys_rst_n), 32'd0);
    check("run_needs_lock_hist", 32'(bus.sys_rst_n & ~hist_ok()), 32'd0);
  endtask

  task automatic run_until_state(input bit lk, input logic [1:0] st, input int bound);
    int n;
    n = 0;
    while (bus.state_dbg !== st && n < bound) begin
      tick(1'b1, lk);
      n++;
    end
    check("reach_state", 32'(bus.state_dbg), 32'(st));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_reset"},  32'(bus.pll_reset),  32'd1);
    check({tag, "_sys_rst_n"},  32'(bus.sys_rst_n),  32'd0);
    check({tag, "_locked"},     32'(bus.locked),     32'd0);
    check({tag, "_fail_count"}, 32'(bus.fail_count), 32'd0);
    check({tag, "_state_dbg"},  32'(bus.state_dbg),  32'd0);
  endtask

  // Monitor: compares every presented output set against the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        check("sb_pll_reset",  32'(bus.pll_reset),  32'(e.pll_reset));
        check("sb_sys_rst_n",  32'(bus.sys_rst_n),  32'(e.sys_rst_n));
        check("sb_locked",     32'(bus.locked),     32'(e.locked));
        check("sb_fail_count", 32'(bus.fail_count), 32'(e.fail_count));
        check("sb_state_dbg",  32'(bus.state_dbg),  32'(e.state_dbg));
      end
    end
  end

  initial begin
    int n;
    int n_st;
    int rises;
    int last_rise;
    int cyc;
    int hold;
    bit prev;
    bit lk;
    bit rn;
    bit saw_reset;

    resetn       = 1'b0;
    bus.pll_lock = 1'b1;
    model_step(1'b0, 1'b0);

    // Power-up with lock already high
    repeat (3) tick(1'b0, 1'b1);
    check_reset_outputs("reset");
    n = 0;
    do begin
      tick(1'b1, 1'b1);
      n++;
    end while (bus.pll_reset && n < 50);
    check("pll_reset_width", 32'(n), 32'(RST_CYCLES));
    n = 0;
    do begin
      tick(1'b1, 1'b1);
      n++;
    end while (!bus.sys_rst_n && n < 50);
    check("release_delay", 32'(n), 32'(1 + STABLE_CYCLES));
    check("locked_in_run", 32'(bus.locked), 32'd1);

    // Lock never arrives: periodic re-pulse and saturating failure count
    repeat (2) tick(1'b0, 1'b0);
    prev      = bus.pll_reset;
    rises     = 0;
    last_rise = 0;
    cyc       = 0;
    while (rises < 4 && cyc < 300) begin
      tick(1'b1, 1'b0);
      cyc++;
      if (bus.pll_reset && !prev) begin
        rises++;
        check("timeout_fail_count", 32'(bus.fail_count), 32'((rises < FAIL_MAX) ? rises : FAIL_MAX));
        if (rises > 1) check("repulse_period", 32'(cyc - last_rise), 32'(RST_CYCLES + LOCK_TIMEOUT));
        last_rise = cyc;
      end
      prev = bus.pll_reset;
    end
    check("repulse_count", 32'(rises), 32'd4);

    // Glitch during STABLE restarts the full window without a failure
    repeat (2) tick(1'b0, 1'b1);
    run_until_state(1'b1, 2'd2, 40);
    repeat (3) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    run_until_state(1'b1, 2'd1, 6);
    check("glitch_no_fail", 32'(bus.fail_count), 32'd0);
    n = 0;
    n_st = 0;
    while (bus.state_dbg !== 2'd3 && n < 50) begin
      tick(1'b1, 1'b1);
      n++;
      if (bus.state_dbg === 2'd2) n_st++;
    end
    check("stable_window", 32'(n_st), 32'(STABLE_CYCLES));

    // Lock loss in RUN
    tick(1'b1, 1'b0);
    n = 1;
    while (bus.sys_rst_n && n < 10) begin
      tick(1'b1, 1'b0);
      n++;
    end
    check("loss_latency", 32'(n), 32'(SYNC_STAGES + 1));
    check("loss_locked", 32'(bus.locked), 32'd0);
    check("loss_fail_count", 32'(bus.fail_count), 32'd1);
    check("loss_state", 32'(bus.state_dbg), 32'd1);
    saw_reset = 1'b0;
    repeat (5) begin
      tick(1'b1, 1'b0);
      saw_reset |= bus.pll_reset;
    end
    n = 0;
    while (bus.state_dbg !== 2'd3 && n < 40) begin
      tick(1'b1, 1'b1);
      n++;
      saw_reset |= bus.pll_reset;
    end
    check("no_pll_reset_on_relock", 32'(saw_reset), 32'd0);
    check("relock_run", 32'(bus.state_dbg), 32'd3);

    // Reset asserted in RUN, then in WAIT_LOCK
    tick(1'b0, 1'b1);
    check_reset_outputs("rst_in_run");
    run_until_state(1'b0, 2'd1, 20);
    tick(1'b0, 1'b0);
    check_reset_outputs("rst_in_wait");

    // Random lock activity with occasional resets
    cyc = 0;
    while (cyc < 10000) begin
      lk   = ($urandom_range(0, 9) < 7);
      hold = $urandom_range(1, 24);
      repeat (hold) begin
        rn = ($urandom_range(0, 499) != 0);
        tick(rn, lk);
        cyc++;
      end
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
